// File: rtl/imgproc_pkg.sv
// rtl/imgproc_pkg.sv - shared types and constants for the raw pattern generator
package imgproc_pkg;

    localparam int PIX_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } pg_state_t;

    localparam logic [1:0] MODE_RAMP    = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_FLAT    = 2'd2;
    localparam logic [1:0] MODE_FRAME   = 2'd3;

endpackage

// File: rtl/raw_pattern_pixel.sv
// rtl/raw_pattern_pixel.sv - combinational pixel value for the selected test pattern
module raw_pattern_pixel
    import imgproc_pkg::*;
(
    input  logic [1:0]       mode,
    input  logic [11:0]      x,
    input  logic [11:0]      y,
    input  logic [3:0]       frame_lsb,
    output logic [PIX_W-1:0] data
);

    always_comb begin
        data = '0;
        case (mode)
            MODE_RAMP:    data = x + y;
            MODE_CHECKER: data = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
            MODE_FLAT:    data = 12'h800;
            default:      data = {frame_lsb, 8'h00};
        endcase
    end

endmodule

// File: rtl/raw_pattern_gen.sv
// rtl/raw_pattern_gen.sv - raster timing FSM and registered output pipeline
module raw_pattern_gen
    import imgproc_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic             iEnd,
    input  logic [1:0]       iMode,
    output logic [PIX_W-1:0] oDATA,
    output logic             oDVAL,
    output logic [15:0]      oX_Cont,
    output logic [15:0]      oY_Cont,
    output logic [31:0]      oFrame_Cont
);

    localparam logic [15:0] X_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

    pg_state_t        state;
    logic [15:0]      x_q;
    logic [15:0]      y_q;
    logic [15:0]      blank_cnt;
    logic [31:0]      frame_q;
    logic             stop_q;
    logic [1:0]       mode_q;
    logic             first_pix;
    logic [1:0]       mode_eff;
    logic [PIX_W-1:0] pix;

    logic             s1_dval;
    logic [15:0]      s1_x;
    logic [15:0]      s1_y;
    logic [31:0]      s1_frame;
    logic [PIX_W-1:0] s1_data;

    // Mode is taken live on the frame's first pixel so it applies to that pixel too.
    assign first_pix = (state == ST_ACTIVE) && (x_q == 16'd0) && (y_q == 16'd0);
    assign mode_eff  = first_pix ? iMode : mode_q;

    raw_pattern_pixel u_pixel (
        .mode      (mode_eff),
        .x         (x_q[11:0]),
        .y         (y_q[11:0]),
        .frame_lsb (frame_q[3:0]),
        .data      (pix)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            blank_cnt <= '0;
            frame_q   <= '0;
            stop_q    <= 1'b0;
            mode_q    <= '0;
        end else begin
            if (state != ST_IDLE && iEnd)
                stop_q <= 1'b1;
            if (first_pix)
                mode_q <= iMode;
            case (state)
                ST_IDLE: begin
                    x_q       <= '0;
                    y_q       <= '0;
                    blank_cnt <= '0;
                    if (iStart && !iEnd)
                        state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (x_q == X_LAST) begin
                        x_q       <= '0;
                        blank_cnt <= '0;
                        state     <= ST_HBLANK;
                    end else begin
                        x_q <= x_q + 16'd1;
                    end
                end
                ST_HBLANK: begin
                    if (blank_cnt == HB_LAST) begin
                        blank_cnt <= '0;
                        if (y_q < Y_LAST) begin
                            y_q   <= y_q + 16'd1;
                            state <= ST_ACTIVE;
                        end else begin
                            y_q   <= '0;
                            state <= ST_VBLANK;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 16'd1;
                    end
                end
                ST_VBLANK: begin
                    if (blank_cnt == VB_LAST) begin
                        blank_cnt <= '0;
                        frame_q   <= frame_q + 32'd1;
                        if (stop_q) begin
                            stop_q <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_ACTIVE;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Two register stages put pixel (0,0) on the outputs two edges after iStart is taken.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_dval     <= 1'b0;
            s1_x        <= '0;
            s1_y        <= '0;
            s1_frame    <= '0;
            s1_data     <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
            oDATA       <= '0;
        end else begin
            s1_dval     <= (state == ST_ACTIVE);
            s1_x        <= x_q;
            s1_y        <= y_q;
            s1_frame    <= frame_q;
            s1_data     <= (state == ST_ACTIVE) ? pix : '0;
            oDVAL       <= s1_dval;
            oX_Cont     <= s1_x;
            oY_Cont     <= s1_y;
            oFrame_Cont <= s1_frame;
            oDATA       <= s1_dval ? s1_data : '0;
        end
    end

endmodule

// File: tb/tb_raw_pattern_gen.sv
// tb/tb_raw_pattern_gen.sv - directed scoreboard bench for raw_pattern_gen
module tb_raw_pattern_gen;

    localparam int H      = 16;
    localparam int V      = 4;
    localparam int HB     = 2;
    localparam int VB     = 3;
    localparam int PERIOD = V * (H + HB) + VB;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iStart = 1'b0;
    logic        iEnd = 1'b0;
    logic [1:0]  iMode = 2'd0;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [15:0] oX_Cont;
    logic [15:0] oY_Cont;
    logic [31:0] oFrame_Cont;

    raw_pattern_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .H_BLANK  (HB),
        .V_BLANK  (VB)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iStart      (iStart),
        .iEnd        (iEnd),
        .iMode       (iMode),
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFrame_Cont (oFrame_Cont)
    );

    always #5 iCLK = ~iCLK;

    typedef logic [75:0] pix_t;

    pix_t        exp_q[$];
    int          sof_q[$];
    int          fc_cyc[$];
    logic [31:0] fc_val[$];
    logic [11:0] cap [2][16][4];

    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          low_run = 0;
    int          nvalid = 0;
    bit          lat_armed = 1'b0;
    bit          line_seen = 1'b0;
    bit          prev_dval = 1'b0;
    logic [31:0] prev_frame = '0;
    logic [31:0] exp_frame = '0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pix(input pix_t obs, input pix_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL pixel observed=%0h expected=%0h (x,y,frame,data)", obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [1:0] m, input int x, input int y,
                                          input logic [31:0] f);
        logic bx;
        logic by;
        bx = ((x >> 3) & 1) != 0;
        by = ((y >> 3) & 1) != 0;
        case (m)
            2'd0:    return 12'((x + y) % 4096);
            2'd1:    return (bx ^ by) ? 12'hFFF : 12'h000;
            2'd2:    return 12'h800;
            default: return {f[3:0], 8'h00};
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] m);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                exp_q.push_back({16'(x), 16'(y), exp_frame, model(m, x, y, exp_frame)});
        exp_frame = exp_frame + 32'd1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        sof_q.delete();
        fc_cyc.delete();
        fc_val.delete();
        prev_frame = '0;
        exp_frame  = '0;
        line_seen  = 1'b0;
        prev_dval  = 1'b0;
        low_run    = 0;
        lat_armed  = 1'b0;
    endtask

    task automatic tick();
        pix_t e;
        @(negedge iCLK);
        cyc++;
        if (oDVAL && !prev_dval) begin
            if (oX_Cont == 16'd0 && oY_Cont == 16'd0) begin
                if (lat_armed) begin
                    check("start_latency", cyc - start_cyc, 3);
                    lat_armed = 1'b0;
                end else if (line_seen) begin
                    check("frame_gap", low_run, HB + VB);
                end
                sof_q.push_back(cyc);
            end else if (line_seen) begin
                check("line_gap", low_run, HB);
            end
            low_run = 0;
        end
        if (oDVAL) begin
            nvalid++;
            line_seen = 1'b1;
            cap[oFrame_Cont[0]][oX_Cont[3:0]][oY_Cont[1:0]] = oDATA;
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", longint'(oDVAL), 0);
            end else begin
                e = exp_q.pop_front();
                check_pix({oX_Cont, oY_Cont, oFrame_Cont, oDATA}, e);
            end
        end else begin
            low_run++;
            check("blank_data", longint'(oDATA), 0);
        end
        if (oFrame_Cont != prev_frame) begin
            fc_cyc.push_back(cyc);
            fc_val.push_back(oFrame_Cont);
            prev_frame = oFrame_Cont;
        end
        prev_dval = oDVAL;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic start_pulse();
        iStart    = 1'b1;
        start_cyc = cyc;
        lat_armed = 1'b1;
        line_seen = 1'b0;
        nvalid    = 0;
        tick();
        iStart = 1'b0;
    endtask

    task automatic end_pulse();
        iEnd = 1'b1;
        tick();
        iEnd = 1'b0;
    endtask

    task automatic wait_pix(input int x, input int y);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            tick();
            if (oDVAL && oX_Cont == 16'(x) && oY_Cont == 16'(y))
                hit = 1'b1;
        end
        check("wait_pix_reached", longint'(hit), 1);
    endtask

    task automatic do_reset();
        iRST = 1'b0;
        #1;
        check("rst_data",  longint'(oDATA), 0);
        check("rst_dval",  longint'(oDVAL), 0);
        check("rst_x",     longint'(oX_Cont), 0);
        check("rst_y",     longint'(oY_Cont), 0);
        check("rst_frame", longint'(oFrame_Cont), 0);
        clear_model();
        tick();
        iRST = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        nvalid = 0;
        run(100);
        check("idle_no_dval", nvalid, 0);

        // Mode 0 single frame, stop requested early in the frame
        iMode = 2'd0;
        push_frame(2'd0);
        start_pulse();
        run(10);
        end_pulse();
        run(PERIOD);
        check("m0_valid_count", nvalid, H * V);
        check("m0_queue_empty", exp_q.size(), 0);
        check("m0_frame_cnt", longint'(oFrame_Cont), 1);
        check("m0_pix_5_2", longint'(cap[0][5][2]), 7);
        run(30);
        check("m0_stays_idle", nvalid, H * V);

        // Mode 1 frame followed by a mode 3 frame
        do_reset();
        iMode = 2'd1;
        push_frame(2'd1);
        push_frame(2'd3);
        start_pulse();
        run(10);
        iMode = 2'd3;
        run(70);
        end_pulse();
        run(80);
        check("m13_valid_count", nvalid, 2 * H * V);
        check("m13_queue_empty", exp_q.size(), 0);
        check("m1_pix_0_0", longint'(cap[0][0][0]), 12'h000);
        check("m1_pix_8_0", longint'(cap[0][8][0]), 12'hFFF);
        check("m1_pix_15_3", longint'(cap[0][15][3]), 12'hFFF);
        check("m3_pix_0_0", longint'(cap[1][0][0]), 12'h100);
        check("m3_pix_15_3", longint'(cap[1][15][3]), 12'h100);
        check("m13_frame_cnt", longint'(oFrame_Cont), 2);

        // Three back-to-back frames
        do_reset();
        iMode = 2'd0;
        push_frame(2'd0);
        push_frame(2'd0);
        push_frame(2'd0);
        start_pulse();
        run(160);
        end_pulse();
        run(80);
        check("run3_valid_count", nvalid, 3 * H * V);
        check("run3_queue_empty", exp_q.size(), 0);
        check("run3_sof_count", sof_q.size(), 3);
        check("run3_fc_count", fc_val.size(), 3);
        for (int i = 0; i < 3 && i < fc_val.size(); i++)
            check("run3_frame_cnt_value", longint'(fc_val[i]), i + 1);
        for (int i = 1; i < fc_cyc.size(); i++)
            check("run3_fc_spacing", fc_cyc[i] - fc_cyc[i-1], PERIOD);
        for (int i = 1; i < sof_q.size(); i++)
            check("run3_frame_period", sof_q[i] - sof_q[i-1], PERIOD);

        // Stop and mode change mid-frame: frame finishes unchanged
        iMode = 2'd0;
        push_frame(2'd0);
        start_pulse();
        wait_pix(2, 1);
        iEnd  = 1'b1;
        iMode = 2'd2;
        tick();
        iEnd = 1'b0;
        run(80);
        check("midstop_valid_count", nvalid, H * V);
        check("midstop_queue_empty", exp_q.size(), 0);
        check("midstop_frame_cnt", longint'(oFrame_Cont), 4);

        // iStart and iEnd together in IDLE: no start
        iStart = 1'b1;
        iEnd   = 1'b1;
        run(3);
        iStart = 1'b0;
        iEnd   = 1'b0;
        run(20);
        check("start_end_both_idle", nvalid, H * V);

        // Asynchronous reset mid-frame, then restart from (0,0)
        iMode = 2'd0;
        push_frame(2'd0);
        start_pulse();
        wait_pix(9, 2);
        do_reset();
        iMode = 2'd0;
        push_frame(2'd0);
        start_pulse();
        run(2);
        check("restart_dval", longint'(oDVAL), 1);
        check("restart_x", longint'(oX_Cont), 0);
        check("restart_y", longint'(oY_Cont), 0);
        check("restart_frame", longint'(oFrame_Cont), 0);
        end_pulse();
        run(80);
        check("restart_valid_count", nvalid, H * V);
        check("restart_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
